mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits.
REQ-002 Parameter DATA_W, default 8, memory data width in bits.
REQ-003 Parameter MAX_LOCK, default 4, maximum consecutive granted cycles one requester may hold by lock.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 reqN  input  1  (N=0,1) requester N wants one memory read this cycle.
REQ-007 addrN  input  ADDR_W  read address of requester N, sampled only in a cycle where gntN=1.
REQ-008 lockN  input  1  requester N asks to keep ownership for its next request (multi-byte fetch, e.g. opcode+operand).
REQ-009 gntN  output  1  combinational grant; read of addrN issued this cycle.
REQ-010 rvalidN  output  1  registered; rdataN holds requester N's read result this cycle.
REQ-011 rdataN  output  DATA_W  read data routed to requester N; value undefined when rvalidN=0.
REQ-012 mem_en  output  1  memory read strobe; equals gnt0|gnt1.
REQ-013 mem_addr  output  ADDR_W  addr0 when gnt0, addr1 when gnt1, 0 otherwise.
REQ-014 mem_rdata  input  DATA_W  synchronous memory output, valid exactly one cycle after mem_en.

Function
REQ-015 Arbiter SHALL issue at most one memory read per cycle; gnt0 and gnt1 SHALL never be high together.
REQ-016 States: ARB (no owner), OWN0, OWN1.
REQ-017 In ARB, single requester SHALL be granted same cycle; if both request, the one selected by the round-robin pointer prio SHALL be granted.
REQ-018 prio SHALL toggle to the other requester after every granted cycle with lock=0 taken in ARB, and after every release from OWNx.
REQ-019 Granted cycle with lockN=1 and lock count below MAX_LOCK SHALL move to OWNN and increment lock count.
REQ-020 In OWNN, only requester N SHALL be granted (while reqN=1); the other requester SHALL see gnt=0 even when requesting.
REQ-021 OWNN SHALL return to ARB after a granted cycle with lockN=0, after any cycle with reqN=0, or when lock count reaches MAX_LOCK (forced release, grant of that cycle still honoured).
REQ-022 Lock count SHALL reset to 0 on every return to ARB; the requester whose ownership was force-released SHALL have lower priority on the next contended cycle.
REQ-023 Read latency: rvalidN SHALL assert exactly one cycle after gntN, with rdataN = mem_rdata that cycle; back-to-back grants SHALL give back-to-back rvalid with no bubble.
REQ-024 Response routing SHALL use a registered owner tag captured at grant, independent of current-cycle requests or state.
REQ-025 No request SHALL wait more than MAX_LOCK+1 cycles while continuously asserted.

Reset
REQ-026 While reset=0 at a clock edge: state=ARB, prio=requester 0, lock count=0, rvalid0=rvalid1=0.
REQ-027 gnt0, gnt1, mem_en SHALL be 0 during any cycle where reset=0.
REQ-028 Reset mid-operation SHALL discard any outstanding read: no rvalid in the cycle after reset is sampled low.

Structure
REQ-029 Shared package SHALL hold the state enum (ARB, OWN0, OWN1), ADDR_W/DATA_W defaults, and the default MAX_LOCK.
REQ-030 Single module; no sub-module required.

Verification
REQ-031 Only req0=1, addr0=0x10, lock0=0 for one cycle -> gnt0=1, mem_addr=0x10 same cycle; rvalid0=1, rdata0=mem_rdata next cycle; rvalid1=0.
REQ-032 req0=req1=1 continuously, no locks, after reset -> grants alternate 0,1,0,1; rvalid alternates one cycle later.
REQ-033 req0 with lock0=1 on first grant then lock0=0 (opcode 0x20, operand 0x21), req1 held high -> gnt0 on two consecutive cycles at 0x20, 0x21; gnt1 on third cycle.
REQ-034 req0 and lock0 held high, MAX_LOCK=4, req1 high -> gnt0 for 4 cycles then gnt1 granted on cycle 5.
REQ-035 reset driven low the cycle after gnt1 -> rvalid1 stays 0, state ARB, next contended request granted to requester 0.
REQ-036 Random req/lock stimulus, 10000 cycles -> never gnt0&gnt1, every grant matched by exactly one rvalid to same requester one cycle later.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-port memory read arbiter.
// Holds the arbiter state encoding and default widths/lock limit.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_LOCK = 4;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester read arbiter for a single synchronous memory port.
// Round-robin in ARB, short ownership locks for multi-byte fetches.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              lock0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_t  r_state;
    logic        r_prio;
    logic [CW-1:0] r_cnt;
    logic        r_vld;
    logic        r_tag;

    logic        w_g0;
    logic        w_g1;
    logic        w_en;
    logic        w_lock;
    logic [CW-1:0] w_cnt_nx;
    logic        w_hold;

    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (reset) begin
            case (r_state)
                ARB: begin
                    if (req0 && (!req1 || !r_prio))
                        w_g0 = 1'b1;
                    else if (req1)
                        w_g1 = 1'b1;
                end
                OWN0:    w_g0 = req0;
                OWN1:    w_g1 = req1;
                default: ;
            endcase
        end
    end

    assign w_en     = w_g0 | w_g1;
    assign w_lock   = w_g1 ? lock1 : lock0;
    assign w_cnt_nx = r_cnt + 1'b1;
    // Lock is only kept while the next count stays below the limit
    assign w_hold   = w_lock && (w_cnt_nx < CW'(MAX_LOCK));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ARB;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_tag   <= 1'b0;
        end else begin
            r_vld <= w_en;
            r_tag <= w_g1;
            if (w_en) begin
                if (w_hold) begin
                    r_state <= w_g1 ? OWN1 : OWN0;
                    r_cnt   <= w_cnt_nx;
                end else begin
                    r_state <= ARB;
                    r_cnt   <= '0;
                    r_prio  <= w_g0;
                end
            end else if (r_state != ARB) begin
                r_state <= ARB;
                r_cnt   <= '0;
                r_prio  <= (r_state == OWN0);
            end
        end
    end

    assign gnt0     = w_g0;
    assign gnt1     = w_g1;
    assign mem_en   = w_en;
    assign mem_addr = w_g0 ? addr0 : (w_g1 ? addr1 : '0);

    // Masking with reset drops a read in flight when reset hits
    assign rvalid0  = r_vld & ~r_tag & reset;
    assign rvalid1  = r_vld & r_tag & reset;
    assign rdata0   = mem_rdata;
    assign rdata1   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table plus random
// traffic against an abstract owner/priority reference model.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_en;
    logic [DW-1:0] rdata0, rdata1, mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad = 0;

    // reference model state
    int owner = -1;
    int cnt = 0;
    int prio = 0;
    int pg = -1;
    logic [AW-1:0] paddr = '0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem_addr ^ 8'hA5;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .lock0(lock0),
        .req1(req1), .addr1(addr1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s @%0t: got %0h want %0h", n, $time, a, e);
        end
    endtask

    task automatic step(input bit rn, input bit r0, input bit r1,
                        input bit l0, input bit l1,
                        input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1,
                        output int g);
        int eg;
        logic [AW-1:0] ea;
        @(negedge clk);
        reset = rn; req0 = r0; req1 = r1;
        lock0 = l0; lock1 = l1; addr0 = a0; addr1 = a1;
        #1;
        if (!rn) eg = -1;
        else if (owner >= 0) eg = ((owner == 0) ? r0 : r1) ? owner : -1;
        else if (r0 && r1) eg = prio;
        else if (r0) eg = 0;
        else if (r1) eg = 1;
        else eg = -1;
        ea = (eg == 0) ? a0 : ((eg == 1) ? a1 : '0);
        chk("gnt0", gnt0, eg == 0);
        chk("gnt1", gnt1, eg == 1);
        chk("mem_en", mem_en, eg >= 0);
        chk("mem_addr", mem_addr, ea);
        chk("rvalid0", rvalid0, rn && pg == 0);
        chk("rvalid1", rvalid1, rn && pg == 1);
        if (rn && pg == 0) chk("rdata0", rdata0, paddr ^ 8'hA5);
        if (rn && pg == 1) chk("rdata1", rdata1, paddr ^ 8'hA5);
        if (!rn) begin
            owner = -1; cnt = 0; prio = 0; pg = -1;
        end else begin
            if (eg < 0 && owner >= 0) begin
                prio = 1 - owner; owner = -1; cnt = 0;
            end else if (eg >= 0) begin
                if (((eg == 0) ? l0 : l1) && cnt + 1 < ML) begin
                    owner = eg; cnt = cnt + 1;
                end else begin
                    owner = -1; cnt = 0; prio = 1 - eg;
                end
            end
            pg = eg;
            paddr = ea;
        end
        g = eg;
    endtask

    typedef struct {
        bit rn, r0, r1, l0, l1;
        logic [7:0] a0, a1;
        bit e0, e1;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit rn, bit r0, bit r1, bit l0, bit l1,
                                logic [7:0] a0, logic [7:0] a1,
                                bit e0, bit e1);
        vec_t v;
        v.rn = rn; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
        v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    initial begin
        int g;
        int seen0;
        // reset, gnt held low even with requests
        tv.push_back(mk(0, 1, 1, 0, 0, 8'h01, 8'h02, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 8'h01, 8'h02, 0, 0));
        // single read
        tv.push_back(mk(1, 1, 0, 0, 0, 8'h10, 8'h00, 1, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        // alternation after reset
        tv.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 8'h30, 8'h40, 1, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 8'h31, 8'h41, 0, 1));
        tv.push_back(mk(1, 1, 1, 0, 0, 8'h32, 8'h42, 1, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 8'h33, 8'h43, 0, 1));
        // opcode + operand lock
        tv.push_back(mk(1, 1, 1, 1, 0, 8'h20, 8'h50, 1, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 8'h21, 8'h50, 1, 0));
        tv.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'h50, 0, 1));
        // forced release at MAX_LOCK
        tv.push_back(mk(1, 1, 1, 1, 0, 8'h60, 8'h70, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 8'h61, 8'h70, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 8'h62, 8'h70, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 8'h63, 8'h70, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 8'h64, 8'h71, 0, 1));
        // reset right after gnt1 kills its response
        tv.push_back(mk(1, 0, 1, 0, 0, 8'h00, 8'h80, 0, 1));
        tv.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h80, 0, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 8'h90, 8'h91, 1, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));

        foreach (tv[i]) begin
            step(tv[i].rn, tv[i].r0, tv[i].r1, tv[i].l0, tv[i].l1,
                 tv[i].a0, tv[i].a1, g);
            chk($sformatf("tbl%0d_g0", i), gnt0, tv[i].e0);
            chk($sformatf("tbl%0d_g1", i), gnt1, tv[i].e1);
        end

        // a continuously asserted request is served within ML+1 cycles
        seen0 = 0;
        for (int i = 0; i < ML + 1; i++) begin
            step(1, 1, 1, 0, 1, 8'hA0, 8'hB0, g);
            if (g == 0) seen0 = 1;
        end
        chk("starve0", seen0, 1);

        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 AW'($urandom), AW'($urandom), g);
            chk("excl", gnt0 & gnt1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
